// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Two-entry skid register with a registered in_ready, flush,
//            BUBBLE_VAL on empty output and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic w_in_fire;
  logic w_out_fire;
  logic w_out_valid;

  assign w_out_valid = (state_q != c_EMPTY);
  assign w_in_fire   = in_valid & in_ready_q;
  assign w_out_fire  = w_out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = c_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        c_EMPTY: begin
          if (w_in_fire) begin
            state_d = c_ONE;
            main_d  = in_data;
          end
        end
        c_ONE: begin
          if (w_in_fire && w_out_fire) begin
            main_d = in_data;
          end else if (w_in_fire) begin
            state_d = c_FULL;
            skid_d  = in_data;
          end else if (w_out_fire) begin
            // Going empty: main must read as a bubble from the next cycle on.
            state_d = c_EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        c_FULL: begin
          if (w_out_fire) begin
            state_d = c_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = c_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Ready is derived from the next state so it is a flop with no out_ready path.
  assign in_ready_d = (state_d != c_FULL);

  always_comb begin
    stall_d = stall_q;
    if (w_out_valid && !out_ready && !flush && (stall_q != c_CNT_MAX)) begin
      stall_d = stall_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= c_EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = w_out_valid;
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Directed table-driven bench for pipe_skid_reg (DATA_W=16, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

  localparam int          DW  = 16;
  localparam int          CW  = 4;
  localparam logic [15:0] BUB = 16'hDEAD;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(
    .DATA_W    (DW),
    .BUBBLE_VAL(BUB),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [CW-1:0] e_st;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_ir, input logic e_ov,
                            input logic [DW-1:0] e_od, input logic [CW-1:0] e_st);
    check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
    check({tag, ".out_data"},  {16'd0, out_data},  {16'd0, e_od});
    check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, {28'd0, e_st});
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    #12;
    rst = 1'b0;
    step();
  endtask

  initial begin
    // Streaming
    vecs[0]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0002, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0003, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, BUB,      4'd0};
    // Back-pressure; 0xC offered in FULL must never appear
    vecs[4]  = '{1'b0, 1'b1, 16'h000A, 1'b0, 1'b1, 1'b1, 16'h000A, 4'd0};
    vecs[5]  = '{1'b0, 1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 4'd1};
    vecs[6]  = '{1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, 16'h000A, 4'd2};
    vecs[7]  = '{1'b0, 1'b1, 16'h000C, 1'b1, 1'b1, 1'b1, 16'h000B, 4'd2};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, BUB,      4'd2};
    // Flush in FULL with in_valid and out_ready high
    vecs[9]  = '{1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 16'h0011, 4'd2};
    vecs[10] = '{1'b0, 1'b1, 16'h0012, 1'b0, 1'b0, 1'b1, 16'h0011, 4'd3};
    vecs[11] = '{1'b1, 1'b1, 16'h0013, 1'b1, 1'b1, 1'b0, BUB,      4'd3};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, BUB,      4'd3};
    // Flush in ONE with back-pressure: no stall increment while flushing
    vecs[13] = '{1'b0, 1'b1, 16'h0014, 1'b0, 1'b1, 1'b1, 16'h0014, 4'd3};
    vecs[14] = '{1'b1, 1'b1, 16'h0015, 1'b0, 1'b1, 1'b0, BUB,      4'd3};
    vecs[15] = '{1'b0, 1'b1, 16'h0016, 1'b1, 1'b1, 1'b1, 16'h0016, 4'd3};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, BUB,      4'd3};
    // ONE hold with back-pressure, then drain
    vecs[17] = '{1'b0, 1'b1, 16'h0021, 1'b0, 1'b1, 1'b1, 16'h0021, 4'd3};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0021, 4'd4};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, BUB,      4'd4};

    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    #2;
    do_reset();
    check_outs("reset", 1'b1, 1'b0, BUB, 4'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_st);
    end

    // Saturation: one held payload, 20 back-pressured cycles
    do_reset();
    drive(1'b0, 1'b1, 16'h0077, 1'b0);
    step();
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("sat%0d", k), {28'd0, stall_cnt}, (k > 15) ? 32'd15 : k);
    end
    check("sat.out_data", {16'd0, out_data}, 32'h0077);

    // Asynchronous reset while FULL
    do_reset();
    drive(1'b0, 1'b1, 16'h0031, 1'b0);
    step();
    drive(1'b0, 1'b1, 16'h0032, 1'b0);
    step();
    check("pre_rst.in_ready", {31'd0, in_ready}, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b1, 1'b0, BUB, 4'd0);
    #2;
    rst = 1'b0;
    drive(1'b0, 1'b1, 16'h0005, 1'b1);
    step();
    check_outs("post_rst", 1'b1, 1'b1, 16'h0005, 4'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    step();
    check_outs("post_rst_drain", 1'b1, 1'b0, BUB, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: DATA_W, default 64, meaning payload width (PC and instruction packed together).
REQ-002 Parameter: BUBBLE_VAL, default 0, meaning the DATA_W-bit value driven when no valid entry is present.
REQ-003 Parameter: CNT_W, default 16, meaning stall-counter width.
REQ-004 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: flush  input  1  synchronous flush; discards all held entries.
REQ-007 Port: in_valid  input  1  upstream has a payload.
REQ-008 Port: in_ready  output  1  block can accept a payload this cycle.
REQ-009 Port: in_data  input  DATA_W  upstream payload.
REQ-010 Port: out_valid  output  1  out_data holds a valid payload.
REQ-011 Port: out_ready  input  1  downstream consumes this cycle.
REQ-012 Port: out_data  output  DATA_W  head payload, or BUBBLE_VAL when out_valid=0.
REQ-013 Port: stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-014 Storage SHALL be two entries: main (drives out_data) and skid; states EMPTY, ONE, FULL.
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 in_ready SHALL be a registered output: 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-018 EMPTY: in_fire -> ONE, main <= in_data.
REQ-019 ONE: in_fire & out_fire -> ONE, main <= in_data; in_fire & !out_fire -> FULL, skid <= in_data; !in_fire & out_fire -> EMPTY; otherwise hold.
REQ-020 FULL: out_fire -> ONE, main <= skid; otherwise hold; no input accepted.
REQ-021 Latency SHALL be 1 cycle from in_fire in EMPTY to out_valid=1; sustained throughput 1 payload/cycle when out_ready=1.
REQ-022 Ordering SHALL be strict FIFO; no payload duplicated or dropped except by flush.
REQ-023 out_data SHALL equal BUBBLE_VAL whenever out_valid=0, including immediately after flush.
REQ-024 flush=1 SHALL override every other input: next state EMPTY, main <= BUBBLE_VAL, any in_fire or out_fire in that cycle discarded from storage.
REQ-025 flush SHALL NOT clear stall_cnt.
REQ-026 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0 and flush=0, and saturate at 2^CNT_W-1.
REQ-027 Simultaneous flush and rst: rst wins.

Reset
REQ-028 On rst=1, asynchronously: state EMPTY, out_valid=0, in_ready=1, out_data=BUBBLE_VAL, skid=BUBBLE_VAL, stall_cnt=0.
REQ-029 Assertion of rst mid-transfer SHALL discard all held payloads; first acceptance is permitted on the first rising edge after deassertion.

Verification
REQ-030 Streaming: out_ready=1, in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later, in_ready stays 1, stall_cnt=0.
REQ-031 Back-pressure: out_ready=0, send 0xA then 0xB -> in_ready=0 after 0xB; stall_cnt counts up; raise out_ready -> 0xA then 0xB delivered in order; 0xC offered while in FULL is not accepted.
REQ-032 Flush in FULL with in_valid=1 and out_ready=1 -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1, the offered payload is never output, and stall_cnt is unchanged.
REQ-033 Saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.
REQ-034 Async reset: assert rst between clock edges while in FULL -> outputs reach reset values before the next edge; after deassertion, 0x5 is accepted and appears one cycle later.
